decode_stage_pipelined: RTL
===========================

Name: decode_stage_pipelined

Overview:
Parametrised, registered successor to the dual-lane combinational decoder. Decodes NUM_LANES fetched instructions per cycle into I-buffer and SIMT control fields and holds them in a one-entry pipeline register per lane. Each lane uses a valid/ready handshake toward the I-buffer and supports per-warp flush on branch redirect. Corrects the dual-lane decoder's known gaps: the I-type/LD destination, Src2 validity for I-type/LD, immediate ALUop, and illegal opcode flagging.

Parameters:
NUM_LANES, 2, number of parallel decode lanes
NUM_WARPS, 8, width of the one-hot warp mask
ADDR_W, 32, PC/target width; must be >= 26

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
if_instr  in  32*NUM_LANES  fetched instruction per lane; lane i occupies [32i+31:32i]
if_pcplus4  in  ADDR_W*NUM_LANES  PC+4 per lane
if_warp  in  NUM_WARPS*NUM_LANES  one-hot warp mask per lane; non-zero means valid
if_ready  out  NUM_LANES  lane can accept this cycle
flush_mask  in  NUM_WARPS  warps to squash, from the branch unit
ib_ready  in  NUM_LANES  I-buffer accepts lane output
id_valid  out  NUM_LANES  lane output register holds a live instruction
id_warp  out  NUM_WARPS*NUM_LANES  registered warp mask
id_instr  out  32*NUM_LANES  registered raw instruction
id_pcplus4  out  ADDR_W*NUM_LANES  registered PC+4
id_src1/id_src2/id_dst  out  5*NUM_LANES each  register specifiers
id_imme  out  16*NUM_LANES  instr[15:0]
id_aluop  out  4*NUM_LANES  ALU operation
id_ctrl  out  16*NUM_LANES  packed flags; bit assignment in Behaviour
pc_upd_mask  out  NUM_WARPS*NUM_LANES  one-cycle warp mask for PC redirect (J/CALL)
pc_target  out  ADDR_W*NUM_LANES  zero-extended instr[25:0]

Behaviour:
- Opcode map (bit4 is .S; both values are accepted where listed):
  - INT 000000/010000
  - ADDI 001000/011000, ANDI 001100/011100, ORI 001101/011101, XORI 001110/011110
  - LD 100011/110011, LDS 100111/110111
  - SW 101011/111011, SWS 101111/111111
  - BEQ 000100/010100, BLT 000111/010111
  - J 000010/010010, CALL 000011 only, RET 000110 only, EXIT 100001 only
- id_ctrl bits:
  - 0 regwrite (INT, I-ALU, LD, LDS)
  - 1 memwrite (SW, SWS)
  - 2 memread (LD, LDS)
  - 3 exit
  - 4 shared (LDS, SWS)
  - 5 src1_valid (all except J, CALL, RET, EXIT)
  - 6 src2_valid (INT, SW, SWS, BEQ, BLT)
  - 7 imme_valid (I-ALU, LD, LDS, SW, SWS)
  - 8 beq, 9 blt, 10 call, 11 ret, 12 jmp
  - 13 dots = opcode[4]
  - 14 illegal: opcode outside the map, or INT with unknown funct
  - 15 tied 0
- Register specifiers: src1 = rs, src2 = rt. dst = rt for I-ALU, LD and LDS; dst = rd otherwise.
- ALUop for INT, by funct: 100000 ADD 0000, 100010 SUB 0001, 011000 MUL 0010, 100100 AND 0011, 100101 OR 0100, 100110 XOR 0101, 000010 SHR 0110, 000000 SHL 0111, unknown 1111.
- ALUop for I-ALU: ADDI 0000, ANDI 0011, ORI 0100, XORI 0101.
- ALUop for LD/LDS/SW/SWS is 0000 (address add). All other opcodes give 0000.
- Handshake per lane i:
  - if_ready[i] = !id_valid[i] | ib_ready[i].
  - Capture when if_ready[i] & |if_warp_i. Latency is 1 cycle.
  - An I-buffer transfer occurs when id_valid & ib_ready.
  - While stalled (id_valid & !ib_ready), all registered fields hold.
- Flush:
  - Held register: id_warp_i <= id_warp_i & ~flush_mask.
  - Capture path: captured mask = if_warp_i & ~flush_mask.
  - If the resulting mask is 0, id_valid drops next cycle and other fields are don't-care.
- PC redirect:
  - pc_upd_mask_i is the captured post-flush mask when the instruction is J or CALL, else 0.
  - It is registered and high for exactly one cycle after capture, independent of ib_ready.
- Lanes are fully independent; there is no inter-lane ordering.
- Reset: id_valid, id_warp, id_ctrl, id_aluop, pc_upd_mask and pc_target = 0; all other data outputs = 0. if_ready = 1 from the first cycle after reset. Reset during a stall discards the held entry.

Optional Feature:
DECODE_PERF_CNT_EN:
- When defined, adds outputs perf_issued (32 bits) and perf_illegal (32 bits).
- perf_issued counts I-buffer transfers summed over all lanes per cycle.
- perf_illegal counts transfers with ctrl[14] set.
- Both counters saturate at 0xFFFFFFFF and reset to 0.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
1. Lane0 ADDI (0x2022_0005), warp 0x01, ib_ready=1 -> next cycle id_valid[0]=1, dst=2, src1=1, aluop=0000, ctrl bits 0,5,7 set, bit6 clear.
2. Lane1 J 0x0800_0040, warp 0x10 -> pc_upd_mask lane1=0x10 for exactly 1 cycle, pc_target=0x40, ctrl[12]=1.
3. Lane0 held with ib_ready=0 for 3 cycles, new input offered -> if_ready[0]=0, outputs stable; ib_ready=1 -> transfer, then the new instruction is captured.
4. Held warp 0x05, flush_mask=0x04 -> id_warp=0x01, id_valid stays 1; then flush_mask=0x01 -> id_valid=0.
5. INT with funct 111111 -> aluop=1111, ctrl[14]=1; with DECODE_PERF_CNT_EN, perf_illegal increments by 1 on transfer.
6. Assert rst mid-stall -> the cycle after reset all id_valid=0 and if_ready all 1.

Source files
------------

// File: rtl/decode_stage_pipelined.sv
// Registered multi-lane instruction decoder with per-lane valid/ready toward the I-buffer,
// per-warp flush and one-cycle PC redirect; `DECODE_PERF_CNT_EN adds transfer/illegal counters.
module decode_stage_pipelined #(
    parameter int NUM_LANES = 2,
    parameter int NUM_WARPS = 8,
    parameter int ADDR_W    = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [32*NUM_LANES-1:0]        if_instr,
    input  logic [ADDR_W*NUM_LANES-1:0]    if_pcplus4,
    input  logic [NUM_WARPS*NUM_LANES-1:0] if_warp,
    output logic [NUM_LANES-1:0]           if_ready,
    input  logic [NUM_WARPS-1:0]           flush_mask,
    input  logic [NUM_LANES-1:0]           ib_ready,
    output logic [NUM_LANES-1:0]           id_valid,
    output logic [NUM_WARPS*NUM_LANES-1:0] id_warp,
    output logic [32*NUM_LANES-1:0]        id_instr,
    output logic [ADDR_W*NUM_LANES-1:0]    id_pcplus4,
    output logic [5*NUM_LANES-1:0]         id_src1,
    output logic [5*NUM_LANES-1:0]         id_src2,
    output logic [5*NUM_LANES-1:0]         id_dst,
    output logic [16*NUM_LANES-1:0]        id_imme,
    output logic [4*NUM_LANES-1:0]         id_aluop,
    output logic [16*NUM_LANES-1:0]        id_ctrl,
    output logic [NUM_WARPS*NUM_LANES-1:0] pc_upd_mask,
    output logic [ADDR_W*NUM_LANES-1:0]    pc_target
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [31:0]                    perf_issued,
    output logic [31:0]                    perf_illegal
`endif
);

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic [31:0]          ins;
        logic [5:0]           op;
        logic [5:0]           fn;
        logic                 is_int, is_ialu, is_ld, is_lds, is_sw, is_sws;
        logic                 is_beq, is_blt, is_j, is_call, is_ret, is_exit;
        logic                 op_known, fn_known;
        logic [3:0]           alu_d;
        logic [15:0]          ctrl_d;
        logic [4:0]           dst_d;
        logic [NUM_WARPS-1:0] cap_warp, held_warp;
        logic                 capture;

        logic                 valid_q;
        logic [NUM_WARPS-1:0] warp_q, pc_upd_q;
        logic [31:0]          instr_q;
        logic [ADDR_W-1:0]    pcplus4_q, target_q;
        logic [4:0]           src1_q, src2_q, dst_q;
        logic [15:0]          imme_q, ctrl_q;
        logic [3:0]           alu_q;

        assign ins = if_instr[32*l +: 32];
        assign op  = ins[31:26];
        assign fn  = ins[5:0];

        always_comb begin
            is_int = 1'b0; is_ialu = 1'b0; is_ld = 1'b0; is_lds = 1'b0;
            is_sw = 1'b0; is_sws = 1'b0; is_beq = 1'b0; is_blt = 1'b0;
            is_j = 1'b0; is_call = 1'b0; is_ret = 1'b0; is_exit = 1'b0;
            op_known = 1'b1;
            fn_known = 1'b1;
            alu_d    = 4'b0000;
            // op[4] is the .S modifier; CALL/RET/EXIT exist only without it
            case (op)
                6'b000000, 6'b010000: is_int = 1'b1;
                6'b001000, 6'b011000: is_ialu = 1'b1;
                6'b001100, 6'b011100: begin is_ialu = 1'b1; alu_d = 4'b0011; end
                6'b001101, 6'b011101: begin is_ialu = 1'b1; alu_d = 4'b0100; end
                6'b001110, 6'b011110: begin is_ialu = 1'b1; alu_d = 4'b0101; end
                6'b100011, 6'b110011: is_ld = 1'b1;
                6'b100111, 6'b110111: is_lds = 1'b1;
                6'b101011, 6'b111011: is_sw = 1'b1;
                6'b101111, 6'b111111: is_sws = 1'b1;
                6'b000100, 6'b010100: is_beq = 1'b1;
                6'b000111, 6'b010111: is_blt = 1'b1;
                6'b000010, 6'b010010: is_j = 1'b1;
                6'b000011:            is_call = 1'b1;
                6'b000110:            is_ret = 1'b1;
                6'b100001:            is_exit = 1'b1;
                default:              op_known = 1'b0;
            endcase
            if (is_int) begin
                case (fn)
                    6'b100000: alu_d = 4'b0000;
                    6'b100010: alu_d = 4'b0001;
                    6'b011000: alu_d = 4'b0010;
                    6'b100100: alu_d = 4'b0011;
                    6'b100101: alu_d = 4'b0100;
                    6'b100110: alu_d = 4'b0101;
                    6'b000010: alu_d = 4'b0110;
                    6'b000000: alu_d = 4'b0111;
                    default: begin alu_d = 4'b1111; fn_known = 1'b0; end
                endcase
            end
            ctrl_d     = '0;
            ctrl_d[0]  = is_int | is_ialu | is_ld | is_lds;
            ctrl_d[1]  = is_sw | is_sws;
            ctrl_d[2]  = is_ld | is_lds;
            ctrl_d[3]  = is_exit;
            ctrl_d[4]  = is_lds | is_sws;
            ctrl_d[5]  = !(is_j | is_call | is_ret | is_exit);
            ctrl_d[6]  = is_int | is_sw | is_sws | is_beq | is_blt;
            ctrl_d[7]  = is_ialu | is_ld | is_lds | is_sw | is_sws;
            ctrl_d[8]  = is_beq;
            ctrl_d[9]  = is_blt;
            ctrl_d[10] = is_call;
            ctrl_d[11] = is_ret;
            ctrl_d[12] = is_j;
            ctrl_d[13] = op[4];
            ctrl_d[14] = !op_known | (is_int & !fn_known);
            dst_d      = (is_ialu | is_ld | is_lds) ? ins[20:16] : ins[15:11];
        end

        assign cap_warp    = if_warp[NUM_WARPS*l +: NUM_WARPS] & ~flush_mask;
        assign held_warp   = warp_q & ~flush_mask;
        assign if_ready[l] = !valid_q | ib_ready[l];
        assign capture     = if_ready[l] & (|if_warp[NUM_WARPS*l +: NUM_WARPS]);

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q   <= 1'b0;
                warp_q    <= '0;
                instr_q   <= '0;
                pcplus4_q <= '0;
                src1_q    <= '0;
                src2_q    <= '0;
                dst_q     <= '0;
                imme_q    <= '0;
                alu_q     <= '0;
                ctrl_q    <= '0;
                pc_upd_q  <= '0;
                target_q  <= '0;
            end else begin
                pc_upd_q <= '0;
                if (capture) begin
                    valid_q   <= |cap_warp;
                    warp_q    <= cap_warp;
                    instr_q   <= ins;
                    pcplus4_q <= if_pcplus4[ADDR_W*l +: ADDR_W];
                    src1_q    <= ins[25:21];
                    src2_q    <= ins[20:16];
                    dst_q     <= dst_d;
                    imme_q    <= ins[15:0];
                    alu_q     <= alu_d;
                    ctrl_q    <= ctrl_d;
                    target_q  <= ADDR_W'(ins[25:0]);
                    pc_upd_q  <= (is_j | is_call) ? cap_warp : '0;
                end else if (valid_q & ib_ready[l]) begin
                    valid_q <= 1'b0;
                end else if (valid_q) begin
                    warp_q  <= held_warp;
                    valid_q <= |held_warp;
                end
            end
        end

        assign id_valid[l]                          = valid_q;
        assign id_warp[NUM_WARPS*l +: NUM_WARPS]     = warp_q;
        assign id_instr[32*l +: 32]                  = instr_q;
        assign id_pcplus4[ADDR_W*l +: ADDR_W]        = pcplus4_q;
        assign id_src1[5*l +: 5]                     = src1_q;
        assign id_src2[5*l +: 5]                     = src2_q;
        assign id_dst[5*l +: 5]                      = dst_q;
        assign id_imme[16*l +: 16]                   = imme_q;
        assign id_aluop[4*l +: 4]                    = alu_q;
        assign id_ctrl[16*l +: 16]                   = ctrl_q;
        assign pc_upd_mask[NUM_WARPS*l +: NUM_WARPS] = pc_upd_q;
        assign pc_target[ADDR_W*l +: ADDR_W]         = target_q;
    end

`ifdef DECODE_PERF_CNT_EN
    logic [31:0] issued_q, illegal_q, n_iss, n_ill;
    logic [32:0] iss_sum, ill_sum;

    always_comb begin
        n_iss = '0;
        n_ill = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (id_valid[l] & ib_ready[l]) begin
                n_iss = n_iss + 32'd1;
                if (id_ctrl[16*l+14]) n_ill = n_ill + 32'd1;
            end
        end
        iss_sum = {1'b0, issued_q} + {1'b0, n_iss};
        ill_sum = {1'b0, illegal_q} + {1'b0, n_ill};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issued_q  <= '0;
            illegal_q <= '0;
        end else begin
            issued_q  <= iss_sum[32] ? 32'hFFFF_FFFF : iss_sum[31:0];
            illegal_q <= ill_sum[32] ? 32'hFFFF_FFFF : ill_sum[31:0];
        end
    end

    assign perf_issued  = issued_q;
    assign perf_illegal = illegal_q;
`endif

endmodule
